lcd_text_driver: RTL and testbench
==================================

LCD_TEXT_DRIVER -- requirements
Module: lcd_text_driver

Interface
REQ-001 Parameter CLK_HZ, default 100000000, meaning system clock frequency used to derive all LCD timing counts.
REQ-002 Parameter T_EN_NS, default 1000, meaning lcd_enable high time per byte in ns.
REQ-003 Parameter T_BYTE_US, default 50, meaning settle time after each byte, lcd_enable low.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 print  input  1  level request to display topLCD/bottomLCD; may be held high continuously.
REQ-007 topLCD  input  128  line 1 text, 16 ASCII bytes; [127:120] is column 0.
REQ-008 bottomLCD  input  128  line 2 text, same packing.
REQ-009 available  output  1  high only in IDLE; request accepted when print is high.
REQ-010 lcd_regsel  output  1  HD44780 RS: 0 command, 1 data.
REQ-011 lcd_enable  output  1  HD44780 E strobe.
REQ-012 lcd_data  output  8  HD44780 DB[7:0]; write-only bus.

Function
REQ-013 Timing counts SHALL be T_EN = CLK_HZ*T_EN_NS/1e9, T_BYTE = CLK_HZ*T_BYTE_US/1e6, T_PWR = CLK_HZ/50 (20 ms), T_CLR = CLK_HZ/500 (2 ms), computed at elaboration; each count minimum 1.
REQ-014 Byte transfer SHALL be: 1 setup cycle with RS/data driven and E=0; T_EN cycles E=1; then T_BYTE cycles E=0 with RS/data held (T_CLR instead of T_BYTE after command 0x01).
REQ-015 States: PWR_WAIT -> INIT -> IDLE -> ADDR1 -> LINE1 -> ADDR2 -> LINE2 -> IDLE.
REQ-016 PWR_WAIT SHALL count T_PWR cycles with E=0, then enter INIT.
REQ-017 INIT SHALL send commands 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 in order (RS=0), then enter IDLE.
REQ-018 In IDLE with print=1, both strings SHALL be latched into internal 256-bit buffer in the same cycle; available drops the next cycle.
REQ-019 Input changes after latching SHALL NOT affect the frame in progress.
REQ-020 Frame SHALL send exactly 34 bytes: 0x80 (RS=0), 16 line-1 bytes column 0..15 (RS=1), 0xC0 (RS=0), 16 line-2 bytes (RS=1).
REQ-021 Any text byte equal to 0x00 SHALL be sent as 0x20; all other values sent unchanged.
REQ-022 After the last byte's T_BYTE wait, driver SHALL return to IDLE; available high that cycle. If print is still high, the next frame starts immediately.
REQ-023 print in any state other than IDLE SHALL be ignored; no queueing.
REQ-024 Character index counter 0..15 SHALL reset on entry to LINE1/LINE2; no wrap beyond 15.

Reset
REQ-025 reset_n low SHALL force, asynchronously: state PWR_WAIT, all counters 0, lcd_enable 0, lcd_regsel 0, lcd_data 0x00, available 0, buffer and last-printed register 0.
REQ-026 Reset mid-byte (E high) SHALL drop E immediately; after release the full power-on sequence restarts.

Configuration
REQ-027 Macro LCD_SKIP_UNCHANGED_EN defined: driver keeps a 256-bit copy of the last fully sent frame; an IDLE request whose strings equal it SHALL produce no bus activity, and available stays high.
REQ-028 Macro undefined: every accepted request sends a full 34-byte frame; no last-frame register is instantiated.
REQ-029 Last-frame register SHALL update only when a frame completes; after reset no frame is considered sent, so the first request always prints.

Verification
REQ-030 CLK_HZ=1000000: reset release -> E stays 0 for 20000 cycles, then six E pulses with data 0x38,0x38,0x38,0x0C,0x01,0x06, RS=0, then available=1.
REQ-031 After init, print=1 for 1 cycle, topLCD="GENIUS!" (left bytes 0x00) -> 34 E pulses; bytes 1..9 = 0x20, bytes 10..16 = "GENIUS!", byte 17 = 0xC0 RS=0.
REQ-032 Change topLCD mid-frame -> transmitted bytes match the value latched at acceptance.
REQ-033 print held high with constant text, macro undefined -> back-to-back frames, available high exactly 1 cycle between frames; macro defined -> one frame, then bus idle and available constant 1.
REQ-034 Assert reset_n=0 during the 10th byte's E pulse -> E falls in the same cycle; after release, 20 ms power wait and INIT repeat.
REQ-035 Every pulse checked: E high exactly T_EN cycles, RS/data stable from the setup cycle to the end of the wait; wait after 0x01 equals T_CLR.

Source files
------------

// File: rtl/lcd_text_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lcd_text_driver: HD44780 8-bit bus driver; power-up init, then 2x16 text   |
// | frames. Define LCD_SKIP_UNCHANGED_EN to suppress re-sending an identical   |
// | frame.                                                       Rev 1.0       |
// +----------------------------------------------------------------------------+
module lcd_text_driver #(
  parameter int CLK_HZ    = 100000000,
  parameter int T_EN_NS   = 1000,
  parameter int T_BYTE_US = 50
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         print,
  input  logic [127:0] topLCD,
  input  logic [127:0] bottomLCD,
  output logic         available,
  output logic         lcd_regsel,
  output logic         lcd_enable,
  output logic [7:0]   lcd_data
);

  localparam longint EN_RAW   = (longint'(CLK_HZ) * longint'(T_EN_NS)) / longint'(1000000000);
  localparam longint BYTE_RAW = (longint'(CLK_HZ) * longint'(T_BYTE_US)) / longint'(1000000);
  localparam longint PWR_RAW  = longint'(CLK_HZ) / longint'(50);
  localparam longint CLR_RAW  = longint'(CLK_HZ) / longint'(500);

  localparam int T_EN   = (EN_RAW   < 1) ? 1 : int'(EN_RAW);
  localparam int T_BYTE = (BYTE_RAW < 1) ? 1 : int'(BYTE_RAW);
  localparam int T_PWR  = (PWR_RAW  < 1) ? 1 : int'(PWR_RAW);
  localparam int T_CLR  = (CLR_RAW  < 1) ? 1 : int'(CLR_RAW);

  localparam int MAX_A   = (T_PWR > T_CLR) ? T_PWR : T_CLR;
  localparam int MAX_B   = (T_BYTE > T_EN) ? T_BYTE : T_EN;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_PWR_WAIT = 3'd0,
    ST_INIT     = 3'd1,
    ST_IDLE     = 3'd2,
    ST_ADDR1    = 3'd3,
    ST_LINE1    = 3'd4,
    ST_ADDR2    = 3'd5,
    ST_LINE2    = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    PH_SETUP = 2'd0,
    PH_EN    = 2'd1,
    PH_WAIT  = 2'd2
  } phase_e;

  state_e             state_q, state_d;
  phase_e             phase_q, phase_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         idx_q, idx_d;
  logic [255:0]       buf_q, buf_d;
  logic               avail_q, avail_d;
  logic               rs_q, rs_d;
  logic               en_q, en_d;
  logic [7:0]         data_q, data_d;

  logic               go;
  logic               go_rs;
  logic [7:0]         go_data;
  logic [CNT_W-1:0]   wait_last;
  logic               skip_req;

  function automatic logic [7:0] init_cmd(input logic [3:0] i);
    case (i)
      4'd0, 4'd1, 4'd2: init_cmd = 8'h38;
      4'd3:             init_cmd = 8'h0C;
      4'd4:             init_cmd = 8'h01;
      default:          init_cmd = 8'h06;
    endcase
  endfunction

  // Column 0 sits in the MSB byte of each line; NUL is shown as a blank.
  function automatic logic [7:0] text_byte(input logic [255:0] b, input logic line2,
                                           input logic [3:0] col);
    logic [255:0] s;
    s = b << {line2, col, 3'b000};
    text_byte = (s[255:248] == 8'h00) ? 8'h20 : s[255:248];
  endfunction

  // Clear-display needs the long settle time before the next byte.
  assign wait_last = (data_q == 8'h01 && !rs_q) ? CNT_W'(T_CLR - 1) : CNT_W'(T_BYTE - 1);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    avail_d = avail_q;
    rs_d    = rs_q;
    en_d    = en_q;
    data_d  = data_q;
    go      = 1'b0;
    go_rs   = 1'b0;
    go_data = 8'h00;

    if (state_q == ST_PWR_WAIT) begin
      if (cnt_q == CNT_W'(T_PWR - 1)) begin
        state_d = ST_INIT;
        idx_d   = 4'd0;
        go      = 1'b1;
        go_data = init_cmd(4'd0);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (state_q == ST_IDLE) begin
      if (print && !skip_req) begin
        buf_d   = {topLCD, bottomLCD};
        state_d = ST_ADDR1;
        avail_d = 1'b0;
        go      = 1'b1;
        go_data = 8'h80;
      end
    end else begin
      case (phase_q)
        PH_SETUP: begin
          en_d    = 1'b1;
          phase_d = PH_EN;
          cnt_d   = '0;
        end
        PH_EN: begin
          if (cnt_q == CNT_W'(T_EN - 1)) begin
            en_d    = 1'b0;
            phase_d = PH_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          if (cnt_q == wait_last) begin
            case (state_q)
              ST_INIT: begin
                if (idx_q == 4'd5) begin
                  state_d = ST_IDLE;
                  avail_d = 1'b1;
                end else begin
                  idx_d   = idx_q + 4'd1;
                  go      = 1'b1;
                  go_data = init_cmd(idx_q + 4'd1);
                end
              end
              ST_ADDR1: begin
                state_d = ST_LINE1;
                idx_d   = 4'd0;
                go      = 1'b1;
                go_rs   = 1'b1;
                go_data = text_byte(buf_q, 1'b0, 4'd0);
              end
              ST_LINE1: begin
                if (idx_q == 4'd15) begin
                  state_d = ST_ADDR2;
                  go      = 1'b1;
                  go_data = 8'hC0;
                end else begin
                  idx_d   = idx_q + 4'd1;
                  go      = 1'b1;
                  go_rs   = 1'b1;
                  go_data = text_byte(buf_q, 1'b0, idx_q + 4'd1);
                end
              end
              ST_ADDR2: begin
                state_d = ST_LINE2;
                idx_d   = 4'd0;
                go      = 1'b1;
                go_rs   = 1'b1;
                go_data = text_byte(buf_q, 1'b1, 4'd0);
              end
              ST_LINE2: begin
                if (idx_q == 4'd15) begin
                  state_d = ST_IDLE;
                  avail_d = 1'b1;
                end else begin
                  idx_d   = idx_q + 4'd1;
                  go      = 1'b1;
                  go_rs   = 1'b1;
                  go_data = text_byte(buf_q, 1'b1, idx_q + 4'd1);
                end
              end
              default: state_d = ST_PWR_WAIT;
            endcase
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end

    // Every new byte starts with one setup cycle: bus driven, E low.
    if (go) begin
      phase_d = PH_SETUP;
      cnt_d   = '0;
      en_d    = 1'b0;
      rs_d    = go_rs;
      data_d  = go_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_PWR_WAIT;
      phase_q <= PH_SETUP;
      cnt_q   <= '0;
      idx_q   <= 4'd0;
      buf_q   <= '0;
      avail_q <= 1'b0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      avail_q <= avail_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      data_q  <= data_d;
    end
  end

`ifdef LCD_SKIP_UNCHANGED_EN
  logic [255:0] last_q, last_d;
  logic         last_valid_q, last_valid_d;

  // Only a completed frame counts as displayed.
  always_comb begin
    last_d       = last_q;
    last_valid_d = last_valid_q;
    if (state_q == ST_LINE2 && state_d == ST_IDLE) begin
      last_d       = buf_q;
      last_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q       <= '0;
      last_valid_q <= 1'b0;
    end else begin
      last_q       <= last_d;
      last_valid_q <= last_valid_d;
    end
  end

  assign skip_req = last_valid_q && ({topLCD, bottomLCD} == last_q);
`else
  assign skip_req = 1'b0;
`endif

  assign available  = avail_q;
  assign lcd_regsel = rs_q;
  assign lcd_enable = en_q;
  assign lcd_data   = data_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_text_driver.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for lcd_text_driver at CLK_HZ = 1 MHz: expected-byte queue model with
// per-pulse timing monitor, plus directed literal checks.
module tb_lcd_text_driver;

  localparam int T_EN   = 1;
  localparam int T_BYTE = 50;
  localparam int T_PWR  = 20000;
  localparam int T_CLR  = 2000;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         print;
  logic [127:0] top_lcd;
  logic [127:0] bottom_lcd;
  logic         available;
  logic         lcd_regsel;
  logic         lcd_enable;
  logic [7:0]   lcd_data;

  lcd_text_driver #(
    .CLK_HZ   (1000000),
    .T_EN_NS  (1000),
    .T_BYTE_US(50)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .print     (print),
    .topLCD    (top_lcd),
    .bottomLCD (bottom_lcd),
    .available (available),
    .lcd_regsel(lcd_regsel),
    .lcd_enable(lcd_enable),
    .lcd_data  (lcd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         gap;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] cap[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         rise_cnt = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
  endtask

  function automatic int wait_of(input logic rs, input logic [7:0] d);
    return (!rs && d == 8'h01) ? T_CLR : T_BYTE;
  endfunction

  task automatic push_byte(input logic rs, input logic [7:0] d, input int gap);
    exp_t e;
    e.rs = rs; e.d = d; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic push_init();
    push_byte(1'b0, 8'h38, -1);
    push_byte(1'b0, 8'h38, T_BYTE + 1);
    push_byte(1'b0, 8'h38, T_BYTE + 1);
    push_byte(1'b0, 8'h0C, T_BYTE + 1);
    push_byte(1'b0, 8'h01, T_BYTE + 1);
    push_byte(1'b0, 8'h06, T_CLR + 1);
  endtask

  task automatic push_frame(input logic [127:0] t, input logic [127:0] b, input int gap0);
    logic [7:0] ch;
    push_byte(1'b0, 8'h80, gap0);
    for (int c = 0; c < 16; c++) begin
      ch = t[127 - 8*c -: 8];
      push_byte(1'b1, (ch == 8'h00) ? 8'h20 : ch, T_BYTE + 1);
    end
    push_byte(1'b0, 8'hC0, T_BYTE + 1);
    for (int c = 0; c < 16; c++) begin
      ch = b[127 - 8*c -: 8];
      push_byte(1'b1, (ch == 8'h00) ? 8'h20 : ch, T_BYTE + 1);
    end
  endtask

  // Bus monitor: pulse width, setup, hold, gaps and byte order against exp_q.
  logic       m_prev_e, m_prev_rs, m_prev_avail, m_have_prev, m_seen_rise, m_stable;
  logic [7:0] m_prev_d, m_cur_d;
  logic       m_cur_rs;
  int         m_high, m_gap, m_pwr;

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      m_prev_e = 1'b0; m_have_prev = 1'b0; m_seen_rise = 1'b0; m_prev_avail = 1'b0;
      m_pwr = 0; m_gap = 0; m_high = 0; m_stable = 1'b1;
      m_prev_rs = 1'b0; m_prev_d = 8'h00;
    end else begin
      if (lcd_enable && !m_prev_e) begin
        rise_cnt++;
        cap.push_back({lcd_regsel, lcd_data});
        check(available == 1'b0, "avail_low_in_pulse", available, 0);
        check({m_prev_rs, m_prev_d} == {lcd_regsel, lcd_data}, "setup_cycle",
              {m_prev_rs, m_prev_d}, {lcd_regsel, lcd_data});
        if (!m_seen_rise)
          check(m_pwr >= T_PWR && m_pwr <= T_PWR + 1, "power_wait", m_pwr, T_PWR);
        if (m_have_prev) check(m_stable, "hold_stable", m_stable, 1);
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_byte", {lcd_regsel, lcd_data}, 0);
        end else begin
          e = exp_q.pop_front();
          check({lcd_regsel, lcd_data} == {e.rs, e.d}, "byte", {lcd_regsel, lcd_data}, {e.rs, e.d});
          if (e.gap >= 0 && m_have_prev) check(m_gap == e.gap, "byte_gap", m_gap, e.gap);
        end
        m_seen_rise = 1'b1; m_have_prev = 1'b1; m_stable = 1'b1;
        m_cur_rs = lcd_regsel; m_cur_d = lcd_data; m_high = 1; m_gap = 0;
      end else if (lcd_enable) begin
        m_high++;
        if ({lcd_regsel, lcd_data} != {m_cur_rs, m_cur_d}) m_stable = 1'b0;
      end else begin
        if (m_prev_e) check(m_high == T_EN, "en_width", m_high, T_EN);
        if (!m_seen_rise) m_pwr++;
        if (m_have_prev) begin
          m_gap++;
          if (m_gap <= wait_of(m_cur_rs, m_cur_d) && {lcd_regsel, lcd_data} != {m_cur_rs, m_cur_d})
            m_stable = 1'b0;
          if (available && !m_prev_avail)
            check(m_gap == wait_of(m_cur_rs, m_cur_d) + 1, "avail_after_wait",
                  m_gap, wait_of(m_cur_rs, m_cur_d) + 1);
        end
      end
      m_prev_e = lcd_enable; m_prev_rs = lcd_regsel; m_prev_d = lcd_data;
      m_prev_avail = available;
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_avail(input int budget, input string name);
    int n = 0;
    while (available !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(available === 1'b1, name, available, 1);
  endtask

  task automatic wait_rises(input int target, input int budget, input string name);
    int n = 0;
    while (rise_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check(rise_cnt >= target, name, rise_cnt, target);
  endtask

  task automatic pulse_print();
    print = 1'b1;
    tick();
    print = 1'b0;
    check(available == 1'b0, "avail_drop", available, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n_av;
    int r0;
    bit ok;
    reset_n = 1'b0; print = 1'b0; top_lcd = '0; bottom_lcd = '0;
    repeat (3) tick();
    check(available == 1'b0, "rst_available", available, 0);
    check(lcd_enable == 1'b0, "rst_enable", lcd_enable, 0);
    check(lcd_regsel == 1'b0, "rst_regsel", lcd_regsel, 0);
    check(lcd_data == 8'h00, "rst_data", lcd_data, 0);

    push_init();
    reset_n = 1'b1;
    wait_avail(T_PWR + 3000, "init_done");
    check(exp_q.size() == 0, "init_all_sent", exp_q.size(), 0);
    check(cap.size() == 6 && cap[4] == 9'h001, "init_clear_cmd", cap[4], 9'h001);

    // Frame 1: "GENIUS!" right-aligned, NUL padding; line 2 has NUL and 0x01 data.
    top_lcd    = "GENIUS!";
    bottom_lcd = {"line two", 8'h00, 8'h01, "xyz", 8'hFF, 8'h00, 8'h7E};
    base = rise_cnt;
    push_frame(top_lcd, bottom_lcd, -1);
    check(exp_q[10].d == 8'h47 && exp_q[1].d == 8'h20 && exp_q[17].d == 8'hC0,
          "model_pin", exp_q[10].d, 8'h47);
    pulse_print();
    wait_avail(3000, "frame1_done");
    check(exp_q.size() == 0, "frame1_all_sent", exp_q.size(), 0);
    check(cap[base + 0] == 9'h080, "f1_addr1", cap[base + 0], 9'h080);
    check(cap[base + 1] == 9'h120, "f1_col0_blank", cap[base + 1], 9'h120);
    check(cap[base + 9] == 9'h120, "f1_col8_blank", cap[base + 9], 9'h120);
    check(cap[base + 10] == 9'h147, "f1_G", cap[base + 10], 9'h147);
    check(cap[base + 16] == 9'h121, "f1_bang", cap[base + 16], 9'h121);
    check(cap[base + 17] == 9'h0C0, "f1_addr2", cap[base + 17], 9'h0C0);
    check(cap[base + 26] == 9'h120, "f1_l2_nul", cap[base + 26], 9'h120);
    check(cap[base + 27] == 9'h101, "f1_l2_01", cap[base + 27], 9'h101);
    check(cap[base + 33] == 9'h17E, "f1_last", cap[base + 33], 9'h17E);

    // Frame 2: inputs change mid-frame; the latched text must be sent.
    top_lcd    = "Frame two text!!";
    bottom_lcd = "0123456789ABCDEF";
    base = rise_cnt;
    push_frame(top_lcd, bottom_lcd, -1);
    pulse_print();
    wait_rises(base + 5, 1000, "f2_started");
    top_lcd    = "ZZZZZZZZZZZZZZZZ";
    bottom_lcd = "YYYYYYYYYYYYYYYY";
    wait_avail(3000, "frame2_done");
    check(exp_q.size() == 0, "frame2_all_sent", exp_q.size(), 0);
    check(cap[base + 1] == 9'h146, "f2_col0_latched", cap[base + 1], 9'h146);
    check(cap[base + 33] == 9'h146, "f2_last_latched", cap[base + 33], 9'h146);

    // print held high with constant text.
    top_lcd    = "Held print top  ";
    bottom_lcd = "Held print bot  ";
    base = rise_cnt;
`ifdef LCD_SKIP_UNCHANGED_EN
    push_frame(top_lcd, bottom_lcd, -1);
    print = 1'b1;
    tick();
    wait_rises(base + 34, 3000, "held_frame");
    wait_avail(200, "held_done");
    r0 = rise_cnt; ok = 1'b1;
    repeat (300) begin
      tick();
      if (available !== 1'b1 || lcd_enable !== 1'b0) ok = 1'b0;
    end
    check(ok && rise_cnt == r0, "skip_unchanged_idle", rise_cnt - r0, 0);
    print = 1'b0;
    check(exp_q.size() == 0, "held_all_sent", exp_q.size(), 0);
`else
    push_frame(top_lcd, bottom_lcd, -1);
    push_frame(top_lcd, bottom_lcd, T_BYTE + 2);
    push_frame(top_lcd, bottom_lcd, T_BYTE + 2);
    print = 1'b1;
    tick();
    n_av = 0;
    for (int n = 0; n < 6000 && rise_cnt < base + 69; n++) begin
      tick();
      if (available) n_av++;
    end
    print = 1'b0;
    check(rise_cnt >= base + 69, "held_third_frame", rise_cnt - base, 69);
    check(n_av == 2, "avail_between_frames", n_av, 2);
    wait_avail(3000, "held_done");
    r0 = rise_cnt; ok = 1'b1;
    repeat (300) begin
      tick();
      if (available !== 1'b1 || lcd_enable !== 1'b0) ok = 1'b0;
    end
    check(ok && rise_cnt == r0, "idle_after_release", rise_cnt - r0, 0);
    check(exp_q.size() == 0, "held_all_sent", exp_q.size(), 0);
`endif

    // Reset during the 10th frame byte's E pulse.
    top_lcd    = "Reset test line1";
    bottom_lcd = "Reset test line2";
    base = rise_cnt;
    push_frame(top_lcd, bottom_lcd, -1);
    pulse_print();
    wait_rises(base + 10, 1000, "tenth_byte");
    check(lcd_enable == 1'b1, "tenth_e_high", lcd_enable, 1);
    reset_n = 1'b0;
    #1;
    check(lcd_enable == 1'b0, "async_e_drop", lcd_enable, 0);
    check({available, lcd_regsel, lcd_data} == 10'h000, "async_outputs_clear",
          {available, lcd_regsel, lcd_data}, 0);
    exp_q.delete();
    repeat (3) tick();
    push_init();
    reset_n = 1'b1;
    wait_avail(T_PWR + 3000, "reinit_done");
    check(exp_q.size() == 0, "reinit_all_sent", exp_q.size(), 0);

    // Same text again after reset must print in full.
    base = rise_cnt;
    push_frame(top_lcd, bottom_lcd, -1);
    pulse_print();
    wait_avail(3000, "frame_after_reset_done");
    check(exp_q.size() == 0 && rise_cnt == base + 34, "frame_after_reset", rise_cnt - base, 34);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
